data_mem_responder: RTL
=======================

# data_mem_responder

Responder side of the data-memory interface driven by the control unit's `mem_read`/`mem_write` signals. Holds a word-addressed data array and serves one load or store at a time with a fixed, parameterised latency. It uses a valid/ready request handshake and a one-cycle response pulse, so the multi-cycle and pipelined cores can stall on memory.

## Interface

Parameters:
- `MEM_DEPTH`, 16384: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4: cycles from request acceptance to response; ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `is_input_valid`  in  1  request present this cycle.
- `mem_read`  in  1  request is a load.
- `mem_write`  in  1  request is a store.
- `addr`  in  32  byte address.
- `din`  in  32  store data.
- `is_ready`  out  1  responder can accept a request this cycle.
- `is_output_valid`  out  1  one-cycle pulse: `dout` holds load data.
- `is_write_done`  out  1  one-cycle pulse: store completed.
- `dout`  out  32  load data.

## Operation

- **Word index.** `addr[1:0]` is ignored. The index is `addr[log2(MEM_DEPTH)+1:2]`. Upper address bits are discarded, so addresses wrap modulo `MEM_DEPTH*4`.
- **Acceptance.** A request is accepted on an edge where `is_input_valid && is_ready` and exactly one of `mem_read` or `mem_write` is 1. On acceptance, `addr`, `din` and the operation type are captured into internal registers. Input changes after acceptance have no effect.
- **Illegal requests.** If `is_input_valid` is 1 and `mem_read == mem_write` (both 1 or both 0), the request is illegal and is not accepted:
  - the FSM stays in IDLE;
  - no response is produced;
  - the array is unchanged.
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE → RESP on acceptance when `LATENCY == 1`.
  - IDLE → BUSY on acceptance when `LATENCY > 1`, loading a down-counter with `LATENCY-1`.
  - In BUSY, the counter decrements on each edge. The edge on which it goes from 1 to 0 moves the FSM to RESP.
  - RESP → IDLE unconditionally after one cycle.
- **Outputs by state.**
  - `is_ready` = 1 only in IDLE.
  - `is_output_valid` = 1 only in RESP for a load.
  - `is_write_done` = 1 only in RESP for a store.
- **Load data.** For a load, `dout` is read from the array on the edge entering RESP. `dout` holds its value until the next load response; it is meaningful only while `is_output_valid` is 1.
- **Store commit.** For a store, the array word is written on the edge that leaves RESP.
- **Reset.** The array contents are not affected by reset; power-up contents are undefined unless preloaded by the bench.

## Timing

- **Reset values.** While `reset` is sampled high and on the following cycle:
  - FSM = IDLE, `is_ready` = 1;
  - `is_output_valid` = 0, `is_write_done` = 0;
  - `dout` = 32'h0;
  - down-counter = 0.
- **Latency.** For a request accepted on the edge ending cycle T:
  - `is_ready` = 0 in cycles T+1 … T+LATENCY;
  - the response pulse is high in cycle T+LATENCY only;
  - `is_ready` = 1 again in cycle T+LATENCY+1.
- **Throughput.** At most one request per LATENCY+1 cycles.
- **Read-after-write.** A store accepted at T is visible to any load accepted at T+LATENCY+1 or later. No request can be accepted earlier than that, so ordering is always program order.
- **Reset mid-operation.** Reset in any non-IDLE state drops the pending request:
  - no response pulse is produced;
  - a pending store is not committed, even if reset is asserted in its RESP cycle;
  - `is_ready` is 1 on the cycle after reset deasserts.
- **`is_input_valid` during BUSY/RESP.** Ignored; the request is not queued. The requester must hold the request until it sees `is_ready`.

## Test plan

1. **Reset.** Assert `reset` for 2 cycles with random inputs, then release → `is_ready`=1, `is_output_valid`=0, `is_write_done`=0, `dout`=0; no response pulses follow.
2. **Store/load, `LATENCY=4`.** Store 32'hDEADBEEF to 0x100 accepted at T → `is_ready`=0 in T+1..T+4, `is_write_done`=1 in T+4 only, `is_ready`=1 in T+5. Then load 0x100 accepted at U → `is_output_valid`=1 in U+4 only with `dout`=32'hDEADBEEF. Repeat with `LATENCY=1`: response in the cycle after acceptance.
3. **Addressing, `MEM_DEPTH=16`.**
   - Store 32'h12345678 to 0x104, then load 0x107 → 32'h12345678 (offset ignored).
   - Store 32'hA5A5A5A5 to 0x40, then load 0x0 → 32'hA5A5A5A5 (wrap).
4. **Illegal requests.** `is_input_valid`=1 with `mem_read`=`mem_write`=1, then with both 0, at address 0x100 → `is_ready` stays 1, no pulses; a later load of 0x100 returns the old data.
5. **Inputs during BUSY.** Store 32'h11111111 to 0x20 accepted; during BUSY toggle `addr`, `din`, `is_input_valid`, `mem_read` → only the original store commits, no extra response occurs; a later load of 0x20 returns 32'h11111111.
6. **Reset mid-operation.** Store 32'hCAFEF00D to 0x80 accepted at T (0x80 preloaded with 0); assert `reset` in T+2 → no `is_write_done` pulse, `is_ready`=1 the cycle after reset; a later load of 0x80 returns 0. Repeat with reset asserted in the RESP cycle → same result.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory serving one load/store at a time; response pulse LATENCY cycles after acceptance.
// is_ready is high only in IDLE; requests seen while busy are dropped, so the requester holds until ready.
module data_mem_responder #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic        is_write_done,
  output logic [31:0] dout
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_read;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_din;
  logic [31:0]   r_dout;
  logic          r_ready;
  logic          r_out_vld;
  logic          r_wr_done;
  logic [31:0]   r_mem [MEM_DEPTH];

  logic [AW-1:0] w_in_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_accept;
  logic          w_load_fire;
  logic          w_unused_addr;

  assign w_in_idx      = addr[AW+1:2];
  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign w_accept      = is_input_valid && (r_state == S_IDLE) && (mem_read ^ mem_write);

  // With single-cycle latency the load reads straight from the incoming address.
  assign w_rd_idx    = (LATENCY == 1) ? w_in_idx : r_addr;
  assign w_load_fire = (LATENCY == 1) ? (w_accept && mem_read)
                                      : ((r_state == S_BUSY) && (r_cnt == CW'(1)) && r_is_read);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_out_vld <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      r_wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_read <= mem_read;
            r_addr    <= w_in_idx;
            r_din     <= din;
            r_ready   <= 1'b0;
            if (LATENCY == 1) begin
              r_state   <= S_RESP;
              r_out_vld <= mem_read;
              r_wr_done <= mem_write;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= S_RESP;
            r_out_vld <= r_is_read;
            r_wr_done <= !r_is_read;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Store commits on the edge leaving RESP, so a reset during RESP still cancels it.
  always_ff @(posedge clk) begin
    if ((r_state == S_RESP) && !r_is_read && !reset) begin
      r_mem[r_addr] <= r_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_load_fire) begin
      r_dout <= r_mem[w_rd_idx];
    end
  end

  assign is_ready        = r_ready;
  assign is_output_valid = r_out_vld;
  assign is_write_done   = r_wr_done;
  assign dout            = r_dout;
endmodule
